bus_responder_mem: RTL and testbench
====================================

Name: bus_responder_mem

Overview:
- Target-side model of the 8088 multiplexed local bus, answering cycles issued by the CPU bus interface.
- Demultiplexes AD/A using ALE and decodes IOM, RD_n, WR_n and INTA_n.
- Serves reads from an internal byte RAM, commits writes, supplies an interrupt vector during INTA, and drives READY with programmable wait cycles.
- Sits in the testbench and FPGA top level between the CPU core and external memory.

Parameters:
- MEM_ADDR_BITS, 12: RAM depth is 2^MEM_ADDR_BITS bytes; the physical address is truncated (mirrored) to this width.
- WAIT_CYCLES, 0: CLKx4 cycles READY is held low after a command strobe falls (0..15).
- INT_VECTOR, 8'h08: byte returned on inAD while INTA_n is low.

Ports:
- CLKx4  input  1  sole clock; all inputs are sampled and all outputs registered on its posedge.
- RESET  input  1  synchronous, active-high reset.
- ALE  input  1  address latch enable from the CPU.
- outAD  input  8  CPU-driven AD[7:0]: address in T1, write data from T3.
- enAD  input  8  per-bit CPU drive enables for outAD.
- A  input  12  CPU address bits [19:8].
- IOM  input  1  1 = memory cycle, 0 = I/O cycle.
- RD_n  input  1  read strobe, active-low.
- WR_n  input  1  write strobe, active-low.
- INTA_n  input  1  interrupt acknowledge, active-low.
- inAD  output  8  data returned to the CPU.
- READY  output  1  wait-state control to the CPU.
- busError  output  1  sticky flag for a protocol violation.
- addrLatched  output  20  latched physical address (debug).

Behaviour:
- Reset values: inAD=8'hFF, READY=1, busError=0, addrLatched=0, state=IDLE, wait counter=0. RAM contents are not reset. RESET mid-cycle aborts the cycle with no write.
- Undriven bits read as 1: an effective bus byte is (outAD & enAD) | ~enAD.
- Address latch: on every clock with ALE=1, addrLatched <= {A[19:8], effective outAD}, and the state goes to ADDR. The value is frozen after ALE falls. A[19:16] status values driven after T2 are ignored.
- Strobe edges are detected against the registered previous value of each strobe.
- IDLE: inAD=FF.
- ADDR:
  - ALE falls -> CMD.
  - RD_n fall -> READ.
  - WR_n fall -> WRITE.
  - INTA_n fall -> INTA.
- READ:
  - Memory cycle (IOM=1): inAD <= RAM[addrLatched[MEM_ADDR_BITS-1:0]], registered, valid 1 CLKx4 after the RD_n fall.
  - I/O cycle: see Optional Feature.
  - inAD holds while RD_n=0. On RD_n rise -> IDLE, inAD=FF next clock.
- WRITE:
  - Write data is sampled on every clock while WR_n=0.
  - On WR_n rise, the last sample is committed to RAM (memory cycle) or to the I/O register (I/O cycle), then -> IDLE.
  - At most one write per strobe.
- INTA: inAD=INT_VECTOR while INTA_n=0 (INTA_n has priority over RD_n); no RAM access. INTA_n rise -> IDLE.
- READY: on any command-strobe fall, READY<=0 if WAIT_CYCLES>0. A 4-bit counter is loaded with WAIT_CYCLES and decrements each clock; READY<=1 on the clock the counter reaches 0. With WAIT_CYCLES=0, READY stays 1.
- busError is set (sticky until RESET) when:
  - RD_n and WR_n are low in the same clock; the cycle is treated as a read and no write is committed.
  - A strobe falls while in IDLE, i.e. with no preceding ALE; the cycle is still served at the stale addrLatched.
  - ALE rises while a strobe is low; the cycle is aborted and no write is committed.
- Wrap-around: addresses above the RAM size alias, so 20'h01234 and 20'h11234 hit the same byte when MEM_ADDR_BITS=12.

Optional Feature:
- Macro: BUS_RESPONDER_IO_EN.
- Defined: 16 byte I/O registers, indexed by addrLatched[3:0] and decoded only when addrLatched[15:4]==0. Reset value is 8'h00. Reads/writes to other I/O addresses read FF and are ignored.
- Undefined: every I/O read returns 8'hFF and every I/O write is discarded. busError behaviour is unchanged.

Test Plan:
- Memory write then read: write 8'h5A to 20'h00123, then read 20'h00123 -> inAD=5A while RD_n=0, FF after RD_n rises; busError=0.
- Aliasing: write 8'hC3 to 20'h10123, read 20'h00123 -> C3.
- Wait states (WAIT_CYCLES=3): READY low for exactly 3 CLKx4 after RD_n falls, then 1. The same holds for a write cycle.
- INTA: INTA_n low with RD_n high -> inAD=08. Assert RD_n low concurrently -> inAD still 08; RAM unchanged.
- I/O with macro: write 8'h77 to port 0x0005, read port 0x0005 -> 77; read port 0x0105 -> FF. Without macro: the port 0x0005 read -> FF.
- Violations: RD_n and WR_n low together -> busError=1, no write (RAM byte retains its old value). RESET mid-write (WR_n low) -> RAM unchanged, READY=1, inAD=FF.

Source files
------------

// File: rtl/bus_responder_mem_if.sv
// bus_responder_mem_if: 8088 multiplexed local bus as seen between the CPU
// bus interface (master) and a target responder (slave).
//
// CPU-driven: ALE, outAD[7:0], enAD[7:0], A[19:8], IOM, RD_n, WR_n, INTA_n
// Target-driven: inAD[7:0], READY, busError, addrLatched[19:0]
interface bus_responder_mem_if;
  logic        ALE;
  logic [7:0]  outAD;
  logic [7:0]  enAD;
  logic [11:0] A;
  logic        IOM;
  logic        RD_n;
  logic        WR_n;
  logic        INTA_n;
  logic [7:0]  inAD;
  logic        READY;
  logic        busError;
  logic [19:0] addrLatched;

  modport master (
    output ALE, outAD, enAD, A, IOM, RD_n, WR_n, INTA_n,
    input  inAD, READY, busError, addrLatched
  );

  modport slave (
    input  ALE, outAD, enAD, A, IOM, RD_n, WR_n, INTA_n,
    output inAD, READY, busError, addrLatched
  );
endinterface

// File: rtl/bus_responder_mem.sv
// bus_responder_mem: target-side model of the 8088 multiplexed local bus.
// Demultiplexes AD/A with ALE, serves reads from an internal byte RAM,
// commits writes on the trailing strobe edge, returns an interrupt vector
// during INTA and inserts programmable wait states on READY.
//
// Ports:
//   CLKx4  - sole clock, everything sampled/registered on its rising edge
//   RESET  - synchronous active-high reset
//   bus    - slave side of bus_responder_mem_if
//            in : ALE, outAD, enAD, A[19:8], IOM, RD_n, WR_n, INTA_n
//            out: inAD, READY, busError (sticky), addrLatched (debug)
//
// Parameters:
//   MEM_ADDR_BITS - RAM holds 2^MEM_ADDR_BITS bytes; upper address bits alias
//   WAIT_CYCLES   - CLKx4 cycles READY stays low after a strobe falls (0..15)
//   INT_VECTOR    - byte returned while INTA_n is low
//
// Build option:
//   BUS_RESPONDER_IO_EN - when defined, 16 byte I/O registers live at I/O
//   ports 0x0000..0x000F; otherwise I/O reads return FF and I/O writes vanish.
module bus_responder_mem #(
  parameter int unsigned MEM_ADDR_BITS = 12,
  parameter int unsigned WAIT_CYCLES   = 0,
  parameter logic [7:0]  INT_VECTOR    = 8'h08
) (
  input logic                CLKx4,
  input logic                RESET,
  bus_responder_mem_if.slave bus
);

  localparam int unsigned MemDepth = 2 ** MEM_ADDR_BITS;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  // StAddr: ALE seen; StCmd: ALE has fallen, waiting for a command strobe.
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StCmd,
    StRead,
    StWrite,
    StInta
  } state_e;

  state_e      stateQ, stateD;
  logic [7:0]  inAdQ, inAdD;
  logic        readyQ, readyD;
  logic        busErrorQ, busErrorD;
  logic [19:0] addrQ, addrD;
  logic [3:0]  waitCntQ, waitCntD;
  logic [7:0]  wrDataQ, wrDataD;
  logic        iomQ, iomD;
  logic        rdPrevQ, wrPrevQ, intaPrevQ, alePrevQ;
  logic        commit;

  logic [7:0]  mem [MemDepth];

  // Undriven AD bits float high.
  logic [7:0] effAd;
  assign effAd = (bus.outAD & bus.enAD) | ~bus.enAD;

  logic rdFall, wrFall, intaFall, aleRise, anyStrobeLow;
  assign rdFall       = rdPrevQ & ~bus.RD_n;
  assign wrFall       = wrPrevQ & ~bus.WR_n;
  assign intaFall     = intaPrevQ & ~bus.INTA_n;
  assign aleRise      = bus.ALE & ~alePrevQ;
  assign anyStrobeLow = ~bus.RD_n | ~bus.WR_n | ~bus.INTA_n;

  // A write strobe falling while RD_n is already low is handled as a read.
  logic startInta, startRd, startWr;
  assign startInta = intaFall;
  assign startRd   = rdFall | (wrFall & ~bus.RD_n);
  assign startWr   = wrFall & bus.RD_n;

  logic [MEM_ADDR_BITS-1:0] memIdx;
  logic [7:0]               memRdData;
  logic [7:0]               ioRdData;
  logic [7:0]               rdMux;

  assign memIdx    = addrQ[MEM_ADDR_BITS-1:0];
  assign memRdData = mem[memIdx];
  assign rdMux     = bus.IOM ? memRdData : ioRdData;

`ifdef BUS_RESPONDER_IO_EN
  logic [7:0] ioRegs [16];
  logic       ioHit;

  assign ioHit    = (addrQ[15:4] == 12'h000);
  assign ioRdData = ioHit ? ioRegs[addrQ[3:0]] : 8'hFF;

  always_ff @(posedge CLKx4) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) begin
        ioRegs[i] <= 8'h00;
      end
    end else if (commit && !iomQ && ioHit) begin
      ioRegs[addrQ[3:0]] <= wrDataQ;
    end
  end
`else
  assign ioRdData = 8'hFF;
`endif

  // RAM contents survive reset; a reset cycle never commits.
  always_ff @(posedge CLKx4) begin
    if (!RESET && commit && iomQ) begin
      mem[memIdx] <= wrDataQ;
    end
  end

  always_comb begin
    stateD    = stateQ;
    inAdD     = inAdQ;
    readyD    = readyQ;
    busErrorD = busErrorQ;
    addrD     = addrQ;
    waitCntD  = waitCntQ;
    wrDataD   = wrDataQ;
    iomD      = iomQ;
    commit    = 1'b0;

    // Wait-state counter: READY returns on the clock the count hits zero.
    if (waitCntQ != 4'd0) begin
      waitCntD = waitCntQ - 4'd1;
      if (waitCntQ == 4'd1) begin
        readyD = 1'b1;
      end
    end
    if ((rdFall || wrFall || intaFall) && (WAIT_CYCLES != 0)) begin
      readyD   = 1'b0;
      waitCntD = WaitInit;
    end

    if (!bus.RD_n && !bus.WR_n) begin
      busErrorD = 1'b1;
    end

    if (bus.ALE) begin
      // A new address phase kills any cycle in flight without committing.
      addrD  = {bus.A, effAd};
      stateD = StAddr;
      inAdD  = 8'hFF;
      if (aleRise && anyStrobeLow) begin
        busErrorD = 1'b1;
      end
    end else begin
      unique case (stateQ)
        StIdle, StAddr, StCmd: begin
          if (stateQ == StAddr) begin
            stateD = StCmd;
          end
          if ((startInta || startRd || startWr) && (stateQ == StIdle)) begin
            // No address phase preceded this strobe; serve the stale address.
            busErrorD = 1'b1;
          end
          if (startInta) begin
            stateD = StInta;
            inAdD  = INT_VECTOR;
          end else if (startRd) begin
            stateD = StRead;
            iomD   = bus.IOM;
            inAdD  = rdMux;
          end else if (startWr) begin
            stateD  = StWrite;
            iomD    = bus.IOM;
            wrDataD = effAd;
          end
        end

        StRead: begin
          if (startInta) begin
            stateD = StInta;
            inAdD  = INT_VECTOR;
          end else if (bus.RD_n) begin
            stateD = StIdle;
            inAdD  = 8'hFF;
          end
        end

        StWrite: begin
          if (startInta) begin
            stateD = StInta;
            inAdD  = INT_VECTOR;
          end else if (!bus.RD_n) begin
            // Overlapping RD_n turns this into a read; the write is dropped.
            stateD = StRead;
            iomD   = bus.IOM;
            inAdD  = rdMux;
          end else if (bus.WR_n) begin
            commit = 1'b1;
            stateD = StIdle;
          end else begin
            wrDataD = effAd;
          end
        end

        StInta: begin
          if (bus.INTA_n) begin
            stateD = StIdle;
            inAdD  = 8'hFF;
          end else begin
            inAdD = INT_VECTOR;
          end
        end

        default: begin
          stateD = StIdle;
          inAdD  = 8'hFF;
        end
      endcase
    end
  end

  always_ff @(posedge CLKx4) begin
    if (RESET) begin
      stateQ    <= StIdle;
      inAdQ     <= 8'hFF;
      readyQ    <= 1'b1;
      busErrorQ <= 1'b0;
      addrQ     <= 20'h00000;
      waitCntQ  <= 4'd0;
      wrDataQ   <= 8'hFF;
      iomQ      <= 1'b1;
      // Track live strobe levels so a strobe held across reset is no new edge.
      rdPrevQ   <= bus.RD_n;
      wrPrevQ   <= bus.WR_n;
      intaPrevQ <= bus.INTA_n;
      alePrevQ  <= bus.ALE;
    end else begin
      stateQ    <= stateD;
      inAdQ     <= inAdD;
      readyQ    <= readyD;
      busErrorQ <= busErrorD;
      addrQ     <= addrD;
      waitCntQ  <= waitCntD;
      wrDataQ   <= wrDataD;
      iomQ      <= iomD;
      rdPrevQ   <= bus.RD_n;
      wrPrevQ   <= bus.WR_n;
      intaPrevQ <= bus.INTA_n;
      alePrevQ  <= bus.ALE;
    end
  end

  assign bus.inAD        = inAdQ;
  assign bus.READY       = readyQ;
  assign bus.busError    = busErrorQ;
  assign bus.addrLatched = addrQ;

endmodule

// File: tb/tb_bus_responder_mem.sv
// tb_bus_responder_mem: drives 8088-style bus cycles into bus_responder_mem
// (WAIT_CYCLES=3) and checks read data through an expected-value queue.
module tb_bus_responder_mem;

  localparam int unsigned WaitCycles = 3;

`ifdef BUS_RESPONDER_IO_EN
  localparam logic [7:0] IoExp = 8'h77;
`else
  localparam logic [7:0] IoExp = 8'hFF;
`endif

  logic CLKx4;
  logic RESET;

  bus_responder_mem_if bus ();

  bus_responder_mem #(
    .MEM_ADDR_BITS(12),
    .WAIT_CYCLES  (WaitCycles),
    .INT_VECTOR   (8'h08)
  ) dut (
    .CLKx4(CLKx4),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLKx4 = 1'b0;
  always #5 CLKx4 = ~CLKx4;

  int nChecks = 0;
  int nErrors = 0;
  logic [7:0] sb [$];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic resetPulse();
    @(negedge CLKx4);
    RESET = 1'b1;
    @(negedge CLKx4);
    @(negedge CLKx4);
    RESET = 1'b0;
  endtask

  task automatic aleCycle(input logic [19:0] addr, input logic iom);
    @(negedge CLKx4);
    bus.ALE   = 1'b1;
    bus.A     = addr[19:8];
    bus.outAD = addr[7:0];
    bus.enAD  = 8'hFF;
    bus.IOM   = iom;
    @(negedge CLKx4);
    bus.ALE  = 1'b0;
    bus.enAD = 8'h00;
  endtask

  task automatic waitReady(input string tag);
    for (int i = 0; i < 20 && bus.READY == 1'b0; i++) begin
      @(negedge CLKx4);
    end
    checkEq({tag, ".ready"}, 32'(bus.READY), 32'd1);
  endtask

  task automatic doRead(input logic [19:0] addr, input logic iom, input logic [7:0] exp,
                        input string tag);
    int lowCnt;
    logic [7:0] want;
    aleCycle(addr, iom);
    @(negedge CLKx4);
    bus.RD_n = 1'b0;
    sb.push_back(exp);
    @(negedge CLKx4);
    want = sb.pop_front();
    checkEq({tag, ".data"}, 32'(bus.inAD), 32'(want));
    lowCnt = 0;
    for (int i = 0; i < 20 && bus.READY == 1'b0; i++) begin
      lowCnt++;
      @(negedge CLKx4);
    end
    checkEq({tag, ".wait"}, 32'(lowCnt), 32'(WaitCycles));
    checkEq({tag, ".hold"}, 32'(bus.inAD), 32'(want));
    bus.RD_n = 1'b1;
    @(negedge CLKx4);
    checkEq({tag, ".idle"}, 32'(bus.inAD), 32'hFF);
  endtask

  task automatic doWrite(input logic [19:0] addr, input logic iom, input logic [7:0] data,
                         input logic [7:0] en, input string tag);
    int lowCnt;
    aleCycle(addr, iom);
    @(negedge CLKx4);
    bus.WR_n  = 1'b0;
    bus.outAD = data;
    bus.enAD  = en;
    @(negedge CLKx4);
    lowCnt = 0;
    for (int i = 0; i < 20 && bus.READY == 1'b0; i++) begin
      lowCnt++;
      @(negedge CLKx4);
    end
    checkEq({tag, ".wait"}, 32'(lowCnt), 32'(WaitCycles));
    bus.WR_n = 1'b1;
    @(negedge CLKx4);
    bus.enAD = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] want;
    RESET      = 1'b1;
    bus.ALE    = 1'b0;
    bus.outAD  = 8'h00;
    bus.enAD   = 8'h00;
    bus.A      = 12'h000;
    bus.IOM    = 1'b1;
    bus.RD_n   = 1'b1;
    bus.WR_n   = 1'b1;
    bus.INTA_n = 1'b1;
    repeat (3) @(negedge CLKx4);
    RESET = 1'b0;
    @(negedge CLKx4);

    checkEq("rst.inAD", 32'(bus.inAD), 32'hFF);
    checkEq("rst.READY", 32'(bus.READY), 32'd1);
    checkEq("rst.busError", 32'(bus.busError), 32'd0);
    checkEq("rst.addr", 32'(bus.addrLatched), 32'h0);

    // Basic write/read, then aliasing through the upper address bits.
    doWrite(20'h00123, 1'b1, 8'h5A, 8'hFF, "wr5A");
    doRead(20'h00123, 1'b1, 8'h5A, "rw");
    checkEq("rw.busError", 32'(bus.busError), 32'd0);
    doWrite(20'h10123, 1'b1, 8'hC3, 8'hFF, "wrC3");
    checkEq("alias.addr", 32'(bus.addrLatched), 32'h10123);
    doRead(20'h00123, 1'b1, 8'hC3, "alias");

    // Only the low nibble is driven; the rest floats high.
    doWrite(20'h00400, 1'b1, 8'h05, 8'h0F, "wrPart");
    doRead(20'h00400, 1'b1, 8'hF5, "undriven");

    // I/O space.
    doWrite(20'h00005, 1'b0, 8'h77, 8'hFF, "ioWr");
    doRead(20'h00005, 1'b0, IoExp, "io");
    doRead(20'h00105, 1'b0, 8'hFF, "ioMiss");

    doWrite(20'h00200, 1'b1, 8'h11, 8'hFF, "pre200");
    doWrite(20'h00300, 1'b1, 8'h33, 8'hFF, "pre300");
    doWrite(20'h00500, 1'b1, 8'h55, 8'hFF, "pre500");

    // INTA, with RD_n joining in halfway.
    aleCycle(20'h00123, 1'b1);
    @(negedge CLKx4);
    bus.INTA_n = 1'b0;
    sb.push_back(8'h08);
    @(negedge CLKx4);
    want = sb.pop_front();
    checkEq("inta.vec", 32'(bus.inAD), 32'(want));
    bus.RD_n = 1'b0;
    sb.push_back(8'h08);
    @(negedge CLKx4);
    want = sb.pop_front();
    checkEq("inta.rd", 32'(bus.inAD), 32'(want));
    waitReady("inta");
    bus.INTA_n = 1'b1;
    bus.RD_n   = 1'b1;
    @(negedge CLKx4);
    checkEq("inta.idle", 32'(bus.inAD), 32'hFF);
    doRead(20'h00123, 1'b1, 8'hC3, "intaRam");
    checkEq("inta.busError", 32'(bus.busError), 32'd0);

    // RD_n and WR_n fall together: served as a read, no write.
    aleCycle(20'h00200, 1'b1);
    @(negedge CLKx4);
    bus.RD_n  = 1'b0;
    bus.WR_n  = 1'b0;
    bus.outAD = 8'h99;
    bus.enAD  = 8'hFF;
    sb.push_back(8'h11);
    @(negedge CLKx4);
    want = sb.pop_front();
    checkEq("both.data", 32'(bus.inAD), 32'(want));
    checkEq("both.busError", 32'(bus.busError), 32'd1);
    waitReady("both");
    bus.RD_n = 1'b1;
    bus.WR_n = 1'b1;
    bus.enAD = 8'h00;
    @(negedge CLKx4);
    doRead(20'h00200, 1'b1, 8'h11, "bothRam");
    checkEq("both.sticky", 32'(bus.busError), 32'd1);

    resetPulse();
    @(negedge CLKx4);
    checkEq("rst2.busError", 32'(bus.busError), 32'd0);

    // ALE rising with WR_n low aborts the write.
    aleCycle(20'h00500, 1'b1);
    @(negedge CLKx4);
    bus.WR_n  = 1'b0;
    bus.outAD = 8'hAA;
    bus.enAD  = 8'hFF;
    @(negedge CLKx4);
    bus.ALE   = 1'b1;
    bus.A     = 12'h005;
    bus.outAD = 8'h00;
    @(negedge CLKx4);
    bus.ALE  = 1'b0;
    bus.enAD = 8'h00;
    @(negedge CLKx4);
    checkEq("ale.busError", 32'(bus.busError), 32'd1);
    waitReady("ale");
    bus.WR_n = 1'b1;
    @(negedge CLKx4);
    doRead(20'h00500, 1'b1, 8'h55, "aleRam");

    resetPulse();

    // Strobe with no address phase: flagged, served at the stale address.
    doRead(20'h00123, 1'b1, 8'hC3, "preStale");
    checkEq("preStale.busError", 32'(bus.busError), 32'd0);
    @(negedge CLKx4);
    bus.RD_n = 1'b0;
    sb.push_back(8'hC3);
    @(negedge CLKx4);
    want = sb.pop_front();
    checkEq("stale.data", 32'(bus.inAD), 32'(want));
    checkEq("stale.busError", 32'(bus.busError), 32'd1);
    waitReady("stale");
    bus.RD_n = 1'b1;
    @(negedge CLKx4);

    // Reset in the middle of a write strobe.
    aleCycle(20'h00300, 1'b1);
    @(negedge CLKx4);
    bus.WR_n  = 1'b0;
    bus.outAD = 8'hEE;
    bus.enAD  = 8'hFF;
    @(negedge CLKx4);
    RESET = 1'b1;
    @(negedge CLKx4);
    checkEq("rstWr.READY", 32'(bus.READY), 32'd1);
    checkEq("rstWr.inAD", 32'(bus.inAD), 32'hFF);
    checkEq("rstWr.busError", 32'(bus.busError), 32'd0);
    RESET = 1'b0;
    @(negedge CLKx4);
    bus.WR_n = 1'b1;
    bus.enAD = 8'h00;
    @(negedge CLKx4);
    checkEq("rstWr.idle", 32'(bus.inAD), 32'hFF);
    doRead(20'h00300, 1'b1, 8'h33, "rstWrRam");

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
